// File: rtl/tag_array_nway_pkg.sv
// rtl/tag_array_nway_pkg.sv - shared cache tag-store defaults, entry layout and FSM state type (TAG_DIRTY_EN switch)
package tag_array_nway_pkg;

    localparam int CACHE_WAYS  = 4;
    localparam int CACHE_DEPTH = 256;
    localparam int CACHE_TAG_W = 20;

`ifdef TAG_DIRTY_EN
    localparam int META_W = 2;
`else
    localparam int META_W = 1;
`endif

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int entry_width(input int tag_w);
        return tag_w + META_W;
    endfunction

endpackage

// File: rtl/tag_array_nway_ram.sv
// rtl/tag_array_nway_ram.sv - tag_way_ram: one way of tag storage, sync read, single bit-masked write port
module tag_way_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 21
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [W-1:0]             i_wmask,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Masked write lets the dirty bit be set without disturbing tag/valid.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tag_array_nway.sv
// rtl/tag_array_nway.sv - N-way set-associative tag store with registered lookup, victim select, sweep (TAG_DIRTY_EN)
module tag_array_nway
    import tag_array_nway_pkg::*;
#(
    parameter int WAYS    = CACHE_WAYS,
    parameter int DEPTH   = CACHE_DEPTH,
    parameter int TAG_W   = CACHE_TAG_W,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int INDEX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               init_busy_o,
    input  logic               lookup_valid_i,
    input  logic [INDEX_W-1:0] lookup_index_i,
    input  logic [TAG_W-1:0]   lookup_tag_i,
    output logic               rsp_valid_o,
    output logic               hit_o,
    output logic [WAY_W-1:0]   hit_way_o,
    output logic [WAY_W-1:0]   victim_way_o,
    output logic               victim_valid_o,
    output logic [TAG_W-1:0]   victim_tag_o,
`ifdef TAG_DIRTY_EN
    input  logic               dirty_set_i,
    output logic               victim_dirty_o,
`endif
    input  logic               fill_en_i,
    input  logic [INDEX_W-1:0] fill_index_i,
    input  logic [WAY_W-1:0]   fill_way_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic               inv_all_i
);

    localparam int ENTRY_W = entry_width(TAG_W);
    localparam int V_BIT   = TAG_W;
`ifdef TAG_DIRTY_EN
    localparam int D_BIT   = TAG_W + 1;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_cnt;
    logic [INDEX_W-1:0] w_cnt_nxt;
    logic               w_busy;
    logic               w_lookup_go;
    logic               w_fill_go;

    logic               w_we    [WAYS];
    logic [INDEX_W-1:0] w_waddr [WAYS];
    logic [ENTRY_W-1:0] w_wdata [WAYS];
    logic [ENTRY_W-1:0] w_wmask [WAYS];
    logic [ENTRY_W-1:0] w_rdata [WAYS];

    logic [WAY_W-1:0]   r_rr [DEPTH];
    logic [WAY_W-1:0]   r_rd_rr;
    logic               r_rsp_valid;
    logic [TAG_W-1:0]   r_cmp_tag;

    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_inv_found;
    logic [WAY_W-1:0]   w_inv_way;
    logic [WAY_W-1:0]   w_victim_way;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == INDEX_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: ;
        endcase
        if (inv_all_i) begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
        end
    end

    assign w_busy      = (r_state == ST_INIT);
    assign w_lookup_go = lookup_valid_i & ~w_busy;
    assign w_fill_go   = fill_en_i & ~w_busy;

    // Sweep owns every write port; otherwise fill beats a dirty-set on the same way.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_we[w]    = 1'b0;
            w_waddr[w] = fill_index_i;
            w_wdata[w] = '0;
            w_wmask[w] = '1;
            if (w_busy) begin
                w_we[w]    = 1'b1;
                w_waddr[w] = r_cnt;
            end else if (w_fill_go && (fill_way_i == WAY_W'(w))) begin
                w_we[w]                 = 1'b1;
                w_wdata[w][TAG_W-1:0]   = fill_tag_i;
                w_wdata[w][V_BIT]       = 1'b1;
            end
`ifdef TAG_DIRTY_EN
            else if (dirty_set_i && (fill_way_i == WAY_W'(w))) begin
                w_we[w]           = 1'b1;
                w_wmask[w]        = '0;
                w_wmask[w][D_BIT] = 1'b1;
                w_wdata[w][D_BIT] = 1'b1;
            end
`endif
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        tag_way_ram #(
            .DEPTH (DEPTH),
            .W     (ENTRY_W)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_we[g]),
            .i_waddr (w_waddr[g]),
            .i_wdata (w_wdata[g]),
            .i_wmask (w_wmask[g]),
            .i_re    (w_lookup_go),
            .i_raddr (lookup_index_i),
            .o_rdata (w_rdata[g])
        );
    end

    // Pointers are storage, not control state: no reset, cleared by the sweep.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_rr[r_cnt] <= '0;
        end else if (w_fill_go && (fill_way_i == r_rr[fill_index_i])) begin
            r_rr[fill_index_i] <= fill_way_i + WAY_W'(1);
        end
        if (w_lookup_go) begin
            r_rd_rr <= r_rr[lookup_index_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_cmp_tag   <= '0;
        end else begin
            r_rsp_valid <= w_lookup_go;
            if (w_lookup_go) begin
                r_cmp_tag <= lookup_tag_i;
            end
        end
    end

    // Scan from the top way down so the lowest-numbered match/invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_rdata[w][V_BIT] && (w_rdata[w][TAG_W-1:0] == r_cmp_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_rdata[w][V_BIT]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    assign w_victim_way = w_inv_found ? w_inv_way : r_rd_rr;

    assign init_busy_o    = w_busy;
    assign rsp_valid_o    = r_rsp_valid;
    assign hit_o          = r_rsp_valid & w_hit;
    assign hit_way_o      = r_rsp_valid ? w_hit_way : '0;
    assign victim_way_o   = r_rsp_valid ? w_victim_way : '0;
    assign victim_valid_o = r_rsp_valid & ~w_inv_found;
    assign victim_tag_o   = r_rsp_valid ? w_rdata[w_victim_way][TAG_W-1:0] : '0;
`ifdef TAG_DIRTY_EN
    assign victim_dirty_o = r_rsp_valid & w_rdata[w_victim_way][V_BIT]
                                        & w_rdata[w_victim_way][D_BIT];
`endif

endmodule

// File: tb/tb_tag_array_nway.sv
// tb/tb_tag_array_nway.sv - directed self-checking bench for tag_array_nway (dirty steps under TAG_DIRTY_EN)
module tb_tag_array_nway;

    logic        clk;
    logic        rst_n;
    logic        init_busy_o;
    logic        lookup_valid_i;
    logic [7:0]  lookup_index_i;
    logic [19:0] lookup_tag_i;
    logic        rsp_valid_o;
    logic        hit_o;
    logic [1:0]  hit_way_o;
    logic [1:0]  victim_way_o;
    logic        victim_valid_o;
    logic [19:0] victim_tag_o;
`ifdef TAG_DIRTY_EN
    logic        dirty_set_i;
    logic        victim_dirty_o;
`endif
    logic        fill_en_i;
    logic [7:0]  fill_index_i;
    logic [1:0]  fill_way_i;
    logic [19:0] fill_tag_i;
    logic        inv_all_i;

    int n_tests;
    int n_fail;
    int n_cyc;
    logic rsp_seen;

    tag_array_nway dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_busy_o    (init_busy_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_index_i (lookup_index_i),
        .lookup_tag_i   (lookup_tag_i),
        .rsp_valid_o    (rsp_valid_o),
        .hit_o          (hit_o),
        .hit_way_o      (hit_way_o),
        .victim_way_o   (victim_way_o),
        .victim_valid_o (victim_valid_o),
        .victim_tag_o   (victim_tag_o),
`ifdef TAG_DIRTY_EN
        .dirty_set_i    (dirty_set_i),
        .victim_dirty_o (victim_dirty_o),
`endif
        .fill_en_i      (fill_en_i),
        .fill_index_i   (fill_index_i),
        .fill_way_i     (fill_way_i),
        .fill_tag_i     (fill_tag_i),
        .inv_all_i      (inv_all_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic do_lookup(input logic [7:0] idx, input logic [19:0] tag);
        lookup_valid_i = 1'b1;
        lookup_index_i = idx;
        lookup_tag_i   = tag;
        tick();
        lookup_valid_i = 1'b0;
    endtask

    task automatic do_fill(input logic [7:0] idx, input logic [1:0] way, input logic [19:0] tag);
        fill_en_i    = 1'b1;
        fill_index_i = idx;
        fill_way_i   = way;
        fill_tag_i   = tag;
        tick();
        fill_en_i = 1'b0;
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (init_busy_o && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        lookup_valid_i = 1'b0;
        lookup_index_i = '0;
        lookup_tag_i   = '0;
        fill_en_i      = 1'b0;
        fill_index_i   = '0;
        fill_way_i     = '0;
        fill_tag_i     = '0;
        inv_all_i      = 1'b0;
`ifdef TAG_DIRTY_EN
        dirty_set_i    = 1'b0;
`endif
        repeat (3) tick();
        check("reset_busy", 32'(init_busy_o), 32'd1);
        check("reset_rsp", 32'(rsp_valid_o), 32'd0);
        check("reset_hit", 32'(hit_o), 32'd0);
        check("reset_vvalid", 32'(victim_valid_o), 32'd0);

        // Lookup held during the sweep must never be answered.
        rst_n = 1'b1;
        lookup_valid_i = 1'b1;
        rsp_seen = 1'b0;
        n_cyc = 0;
        while (init_busy_o && n_cyc < 1000) begin
            tick();
            n_cyc++;
            rsp_seen = rsp_seen | rsp_valid_o;
        end
        check("sweep_len", 32'(n_cyc), 32'd256);
        check("no_rsp_busy", 32'(rsp_seen), 32'd0);
        tick();
        lookup_valid_i = 1'b0;
        check("post_init_rsp", 32'(rsp_valid_o), 32'd1);
        check("post_init_hit", 32'(hit_o), 32'd0);
        check("post_init_vway", 32'(victim_way_o), 32'd0);
        check("post_init_vvalid", 32'(victim_valid_o), 32'd0);

        do_fill(8'd5, 2'd2, 20'hABCDE);
        do_lookup(8'd5, 20'hABCDE);
        check("idx5_rsp", 32'(rsp_valid_o), 32'd1);
        check("idx5_hit", 32'(hit_o), 32'd1);
        check("idx5_hitway", 32'(hit_way_o), 32'd2);
        check("idx5_vway", 32'(victim_way_o), 32'd0);
        check("idx5_vvalid", 32'(victim_valid_o), 32'd0);
        tick();
        check("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);

        for (int w = 0; w < 4; w++) do_fill(8'd9, 2'(w), 20'h100 + 20'(w));
        do_lookup(8'd9, 20'h999);
        check("idx9_miss", 32'(hit_o), 32'd0);
        check("idx9_vvalid", 32'(victim_valid_o), 32'd1);
        check("idx9_vway0", 32'(victim_way_o), 32'd0);
        check("idx9_vtag0", 32'(victim_tag_o), 32'h100);
        do_fill(8'd9, 2'd0, 20'h200);
        do_lookup(8'd9, 20'h999);
        check("idx9_vway1", 32'(victim_way_o), 32'd1);
        check("idx9_vtag1", 32'(victim_tag_o), 32'h101);
        do_fill(8'd9, 2'd2, 20'h200);
        do_lookup(8'd9, 20'h200);
        check("idx9_dup_way", 32'(hit_way_o), 32'd0);
        do_lookup(8'd9, 20'h103);
        check("idx9_way3", 32'(hit_way_o), 32'd3);

        fill_en_i = 1'b1; fill_index_i = 8'd3; fill_way_i = 2'd1; fill_tag_i = 20'h12345;
        do_lookup(8'd3, 20'h12345);
        fill_en_i = 1'b0;
        check("rbw_rsp", 32'(rsp_valid_o), 32'd1);
        check("rbw_hit", 32'(hit_o), 32'd0);
        do_lookup(8'd3, 20'h12345);
        check("rbw_hit_after", 32'(hit_o), 32'd1);
        check("rbw_way_after", 32'(hit_way_o), 32'd1);

        do_lookup(8'd4, 20'h55);
        fill_en_i = 1'b1; fill_index_i = 8'd4; fill_way_i = 2'd0; fill_tag_i = 20'h55;
        #1;
        check("fill_after_lkp", 32'(hit_o), 32'd0);
        tick();
        fill_en_i = 1'b0;
        do_lookup(8'd4, 20'h55);
        check("idx4_hit", 32'(hit_o), 32'd1);

        inv_all_i = 1'b1;
        tick();
        inv_all_i = 1'b0;
        check("inv_busy", 32'(init_busy_o), 32'd1);
        repeat (100) tick();
        inv_all_i = 1'b1;
        tick();
        inv_all_i = 1'b0;
        count_sweep(n_cyc);
        check("restart_len", 32'(n_cyc), 32'd256);
        do_lookup(8'd5, 20'hABCDE);
        check("inv_idx5", 32'(hit_o), 32'd0);
        do_lookup(8'd9, 20'h103);
        check("inv_idx9", 32'(hit_o), 32'd0);
        do_lookup(8'd3, 20'h12345);
        check("inv_idx3", 32'(hit_o), 32'd0);

`ifdef TAG_DIRTY_EN
        do_fill(8'd7, 2'd1, 20'h777);
        dirty_set_i = 1'b1; fill_index_i = 8'd7; fill_way_i = 2'd1;
        tick();
        dirty_set_i = 1'b0;
        do_fill(8'd7, 2'd0, 20'h700);
        do_fill(8'd7, 2'd2, 20'h702);
        do_fill(8'd7, 2'd3, 20'h703);
        do_lookup(8'd7, 20'h999);
        check("dirty_vway", 32'(victim_way_o), 32'd1);
        check("dirty_vtag", 32'(victim_tag_o), 32'h777);
        check("dirty_bit", 32'(victim_dirty_o), 32'd1);
`endif

        do_fill(8'd9, 2'd0, 20'h42);
        lookup_valid_i = 1'b1; lookup_index_i = 8'd9; lookup_tag_i = 20'h42;
        tick();
        lookup_valid_i = 1'b0;
        check("pre_rst_rsp", 32'(rsp_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_drop", 32'(rsp_valid_o), 32'd0);
        check("rst_busy", 32'(init_busy_o), 32'd1);
        tick();
        rst_n = 1'b1;
        count_sweep(n_cyc);
        check("rst_sweep_len", 32'(n_cyc), 32'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
